inst_fetcher: RTL and testbench

Front-end instruction fetcher. It is the supplier side of the fetch→decode interface: it presents one instruction at a time (`valid`, `inst`, `inst_addr`, `start_decoder`) to the decoder and consumes the decoder's `issue_signal` and `next_pc`. On ROB misprediction it redirects to `correct_pc`. It holds a direct-mapped, one-word-per-line instruction cache and fills misses from the memory controller over a request/ready handshake.

---
 rtl/inst_fetcher_if.sv | 35 +++
 rtl/inst_fetcher.sv | 143 ++++++++++++++
 tb/tb_inst_fetcher.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetcher_if.sv
// Fetch-side bundle of inst_fetcher.
// Purpose : groups the decoder handshake, the ROB redirect and the memory
//           controller request/response into one port.
// Signals : valid/start_decoder/inst/inst_addr  -> decoder
//           issue_signal/next_pc                <- decoder
//           wrong_predicted/correct_pc          <- ROB
//           mem_req/mem_addr                    -> memory controller
//           mem_ready/mem_data                  <- memory controller
// Modports: master = fetcher side, slave = environment side.
interface inst_fetcher_if;
    logic        valid;
    logic        start_decoder;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        issue_signal;
    logic [31:0] next_pc;
    logic        wrong_predicted;
    logic [31:0] correct_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;

    modport master (
        output valid, start_decoder, inst, inst_addr, mem_req, mem_addr,
        input  issue_signal, next_pc, wrong_predicted, correct_pc,
               mem_ready, mem_data
    );

    modport slave (
        input  valid, start_decoder, inst, inst_addr, mem_req, mem_addr,
        output issue_signal, next_pc, wrong_predicted, correct_pc,
               mem_ready, mem_data
    );
endinterface

// File: rtl/inst_fetcher.sv
// inst_fetcher: front-end instruction fetcher with a direct-mapped,
// one-word-per-line instruction cache.
// Ports:
//   clk_in  - system clock
//   rst_in  - synchronous active-high reset
//   rdy_in  - global ready; when low every register and cache line holds
//   bus     - inst_fetcher_if.master (decoder, ROB redirect, memory port)
// One instruction buffer entry is presented to the decoder at a time. A miss
// parks the fetcher in WAIT until the memory controller answers; a redirect
// during WAIT lets the response land in the cache but not in the buffer.
module inst_fetcher #(
    parameter int ICACHE_IDX_BIT = 6
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    inst_fetcher_if.master bus
);
    localparam int LINES = 1 << ICACHE_IDX_BIT;
    localparam int TAG_W = 30 - ICACHE_IDX_BIT;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_valid, w_valid_nxt;
    logic [31:0] r_inst, w_inst_nxt;
    logic [31:0] r_inst_addr, w_inst_addr_nxt;
    logic        r_mem_req, w_mem_req_nxt;
    logic [31:0] r_mem_addr, w_mem_addr_nxt;
    logic        r_drop, w_drop_nxt;
    logic        w_cache_we;

    logic [LINES-1:0] r_cvld;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    // Lookup uses the current pc; the fill uses the outstanding request
    // address, since pc may already have been redirected.
    logic [ICACHE_IDX_BIT-1:0] w_ridx, w_widx;
    logic [TAG_W-1:0]          w_rtag, w_wtag;
    logic                      w_hit;

    assign w_ridx = r_pc[ICACHE_IDX_BIT+1:2];
    assign w_rtag = r_pc[31:ICACHE_IDX_BIT+2];
    assign w_widx = r_mem_addr[ICACHE_IDX_BIT+1:2];
    assign w_wtag = r_mem_addr[31:ICACHE_IDX_BIT+2];
    assign w_hit  = r_cvld[w_ridx] && (r_tag[w_ridx] == w_rtag);

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_valid_nxt     = r_valid;
        w_inst_nxt      = r_inst;
        w_inst_addr_nxt = r_inst_addr;
        w_mem_req_nxt   = r_mem_req;
        w_mem_addr_nxt  = r_mem_addr;
        w_drop_nxt      = r_drop;
        w_cache_we      = 1'b0;

        if (bus.wrong_predicted) begin
            // Redirect wins over issue; an outstanding request is drained,
            // not cancelled, so the memory controller never sees a retract.
            w_valid_nxt = 1'b0;
            w_pc_nxt    = bus.correct_pc;
            if (r_state == S_WAIT) begin
                if (bus.mem_ready) begin
                    w_cache_we    = 1'b1;
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_drop_nxt = 1'b1;
                end
            end
        end else if (r_state == S_WAIT) begin
            if (bus.mem_ready) begin
                w_cache_we    = 1'b1;
                w_mem_req_nxt = 1'b0;
                w_state_nxt   = S_IDLE;
                if (!r_drop) begin
                    w_valid_nxt     = 1'b1;
                    w_inst_nxt      = bus.mem_data;
                    w_inst_addr_nxt = r_mem_addr;
                end
            end
        end else if (r_valid) begin
            if (bus.issue_signal) begin
                w_pc_nxt    = bus.next_pc;
                w_valid_nxt = 1'b0;
            end
        end else if (w_hit) begin
            w_valid_nxt     = 1'b1;
            w_inst_nxt      = r_data[w_ridx];
            w_inst_addr_nxt = r_pc;
        end else begin
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = {r_pc[31:2], 2'b00};
            w_state_nxt    = S_WAIT;
            w_drop_nxt     = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_valid     <= 1'b0;
            r_inst      <= '0;
            r_inst_addr <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_drop      <= 1'b0;
            r_cvld      <= '0;
        end else if (rdy_in) begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_valid     <= w_valid_nxt;
            r_inst      <= w_inst_nxt;
            r_inst_addr <= w_inst_addr_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_drop      <= w_drop_nxt;
            if (w_cache_we) begin
                r_cvld[w_widx] <= 1'b1;
            end
        end
    end

    // Tag/data storage carries no reset; the per-line valid bits guard it.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && w_cache_we) begin
            r_tag[w_widx]  <= w_wtag;
            r_data[w_widx] <= bus.mem_data;
        end
    end

    assign bus.valid         = r_valid;
    assign bus.start_decoder = r_valid;
    assign bus.inst          = r_inst;
    assign bus.inst_addr     = r_inst_addr;
    assign bus.mem_req       = r_mem_req;
    assign bus.mem_addr      = r_mem_addr;
endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher. Inputs change and outputs are sampled
// on the falling clock edge; the design acts on the rising edge.
module tb_inst_fetcher;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    int   errors = 0;
    int   checks = 0;

    localparam logic [31:0] W000 = 32'h00500093;
    localparam logic [31:0] W004 = 32'h00A00113;
    localparam logic [31:0] W008 = 32'h002081B3;
    localparam logic [31:0] W040 = 32'h12345678;
    localparam logic [31:0] W100 = 32'hFE010113;

    inst_fetcher_if bus();

    inst_fetcher #(.ICACHE_IDX_BIT(6)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Answer the outstanding request: mem_ready is sampled lat edges from now.
    task automatic serve(input int lat, input logic [31:0] data);
        repeat (lat - 1) tick();
        bus.mem_ready = 1'b1;
        bus.mem_data  = data;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_data  = '0;
    endtask

    task automatic issue(input logic [31:0] npc);
        bus.issue_signal = 1'b1;
        bus.next_pc      = npc;
        tick();
        bus.issue_signal = 1'b0;
        bus.next_pc      = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", bus.valid); end
        checks++; if (bus.start_decoder !== 1'b0) begin errors++; $display("FAIL rst_start got=%0h exp=0", bus.start_decoder); end
        checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL rst_inst got=%h exp=0", bus.inst); end
        checks++; if (bus.inst_addr !== 32'h0) begin errors++; $display("FAIL rst_inst_addr got=%h exp=0", bus.inst_addr); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got=%0h exp=0", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got=%h exp=0", bus.mem_addr); end
        rst = 1'b0;
    endtask

    task automatic test_cold_start();
        tick();
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL cold_req got=%0h exp=1", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL cold_addr got=%h exp=0", bus.mem_addr); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL cold_valid0 got=%0h exp=0", bus.valid); end
        serve(3, W000);
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL cold_valid got=%0h exp=1", bus.valid); end
        checks++; if (bus.start_decoder !== 1'b1) begin errors++; $display("FAIL cold_start got=%0h exp=1", bus.start_decoder); end
        checks++; if (bus.inst !== W000) begin errors++; $display("FAIL cold_inst got=%h exp=%h", bus.inst, W000); end
        checks++; if (bus.inst_addr !== 32'h0) begin errors++; $display("FAIL cold_inst_addr got=%h exp=0", bus.inst_addr); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL cold_req_low got=%0h exp=0", bus.mem_req); end
    endtask

    task automatic test_hit_path();
        issue(32'h4);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL hit_issue_valid got=%0h exp=0", bus.valid); end
        tick();
        checks++; if (bus.mem_addr !== 32'h4) begin errors++; $display("FAIL hit_fill4_addr got=%h exp=4", bus.mem_addr); end
        serve(2, W004);
        checks++; if (bus.inst !== W004) begin errors++; $display("FAIL hit_fill4_inst got=%h exp=%h", bus.inst, W004); end
        // Redirect to 0x0 with a coincident issue that must be ignored.
        bus.wrong_predicted = 1'b1;
        bus.correct_pc      = 32'h0;
        bus.issue_signal    = 1'b1;
        bus.next_pc         = 32'h8;
        tick();
        bus.wrong_predicted = 1'b0;
        bus.correct_pc      = '0;
        bus.issue_signal    = 1'b0;
        bus.next_pc         = '0;
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL hit_redir_valid got=%0h exp=0", bus.valid); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL hit_redir_req got=%0h exp=0", bus.mem_req); end
        tick();
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL hit_valid got=%0h exp=1", bus.valid); end
        checks++; if (bus.inst !== W000) begin errors++; $display("FAIL hit_inst got=%h exp=%h", bus.inst, W000); end
        checks++; if (bus.inst_addr !== 32'h0) begin errors++; $display("FAIL hit_inst_addr got=%h exp=0", bus.inst_addr); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL hit_req got=%0h exp=0", bus.mem_req); end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got=%0h exp=1", i, bus.valid); end
            checks++; if (bus.inst !== W000) begin errors++; $display("FAIL hold_inst[%0d] got=%h exp=%h", i, bus.inst, W000); end
            checks++; if (bus.inst_addr !== 32'h0) begin errors++; $display("FAIL hold_addr[%0d] got=%h exp=0", i, bus.inst_addr); end
            checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d] got=%0h exp=0", i, bus.mem_req); end
        end
        issue(32'h8);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL hold_issue_valid got=%0h exp=0", bus.valid); end
        tick();
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL hold_miss_req got=%0h exp=1", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h8) begin errors++; $display("FAIL hold_miss_addr got=%h exp=8", bus.mem_addr); end
        serve(1, W008);
        checks++; if (bus.inst !== W008) begin errors++; $display("FAIL hold_fill_inst got=%h exp=%h", bus.inst, W008); end
        checks++; if (bus.inst_addr !== 32'h8) begin errors++; $display("FAIL hold_fill_addr got=%h exp=8", bus.inst_addr); end
    endtask

    task automatic test_flush_miss();
        issue(32'h100);
        tick();
        checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL flush_req_addr got=%h exp=100", bus.mem_addr); end
        bus.wrong_predicted = 1'b1;
        bus.correct_pc      = 32'h40;
        tick();
        bus.wrong_predicted = 1'b0;
        bus.correct_pc      = '0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL flush_hold_req[%0d] got=%0h exp=1", i, bus.mem_req); end
            checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL flush_hold_addr[%0d] got=%h exp=100", i, bus.mem_addr); end
            checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL flush_hold_valid[%0d] got=%0h exp=0", i, bus.valid); end
            if (i < 2) tick();
        end
        serve(1, W100);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL flush_drop_valid got=%0h exp=0", bus.valid); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL flush_drop_req got=%0h exp=0", bus.mem_req); end
        tick();
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL flush_redir_req got=%0h exp=1", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h40) begin errors++; $display("FAIL flush_redir_addr got=%h exp=40", bus.mem_addr); end
        serve(2, W040);
        checks++; if (bus.inst_addr !== 32'h40) begin errors++; $display("FAIL flush_inst_addr got=%h exp=40", bus.inst_addr); end
        checks++; if (bus.inst !== W040) begin errors++; $display("FAIL flush_inst got=%h exp=%h", bus.inst, W040); end
        // The drained response for 0x100 must now be a hit.
        issue(32'h100);
        tick();
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL flush_hit100_valid got=%0h exp=1", bus.valid); end
        checks++; if (bus.inst !== W100) begin errors++; $display("FAIL flush_hit100_inst got=%h exp=%h", bus.inst, W100); end
        checks++; if (bus.inst_addr !== 32'h100) begin errors++; $display("FAIL flush_hit100_addr got=%h exp=100", bus.inst_addr); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL flush_hit100_req got=%0h exp=0", bus.mem_req); end
    endtask

    task automatic test_conflict();
        // 0x100 evicted 0x0 from line 0.
        issue(32'h0);
        tick();
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL conflict_req got=%0h exp=1", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL conflict_addr got=%h exp=0", bus.mem_addr); end
        serve(1, W000);
        checks++; if (bus.inst !== W000) begin errors++; $display("FAIL conflict_inst got=%h exp=%h", bus.inst, W000); end
    endtask

    task automatic test_back_to_back();
        issue(32'h4);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL b2b_bubble4 got=%0h exp=0", bus.valid); end
        tick();
        checks++; if (bus.inst !== W004) begin errors++; $display("FAIL b2b_inst4 got=%h exp=%h", bus.inst, W004); end
        checks++; if (bus.inst_addr !== 32'h4) begin errors++; $display("FAIL b2b_addr4 got=%h exp=4", bus.inst_addr); end
        issue(32'h8);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL b2b_bubble8 got=%0h exp=0", bus.valid); end
        tick();
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL b2b_valid8 got=%0h exp=1", bus.valid); end
        checks++; if (bus.inst !== W008) begin errors++; $display("FAIL b2b_inst8 got=%h exp=%h", bus.inst, W008); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL b2b_req got=%0h exp=0", bus.mem_req); end
    endtask

    task automatic test_freeze_reset();
        issue(32'h200);
        tick();
        checks++; if (bus.mem_addr !== 32'h200) begin errors++; $display("FAIL frz_req_addr got=%h exp=200", bus.mem_addr); end
        rdy                 = 1'b0;
        bus.wrong_predicted = 1'b1;
        bus.correct_pc      = 32'h44;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL frz_req[%0d] got=%0h exp=1", i, bus.mem_req); end
            checks++; if (bus.mem_addr !== 32'h200) begin errors++; $display("FAIL frz_addr[%0d] got=%h exp=200", i, bus.mem_addr); end
            checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL frz_valid[%0d] got=%0h exp=0", i, bus.valid); end
            checks++; if (bus.inst !== W008) begin errors++; $display("FAIL frz_inst[%0d] got=%h exp=%h", i, bus.inst, W008); end
            checks++; if (bus.inst_addr !== 32'h8) begin errors++; $display("FAIL frz_iaddr[%0d] got=%h exp=8", i, bus.inst_addr); end
        end
        bus.wrong_predicted = 1'b0;
        bus.correct_pc      = '0;
        rdy                 = 1'b1;
        tick();
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL frz_after_req got=%0h exp=1", bus.mem_req); end
        rst = 1'b1;
        tick();
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL wrst_valid got=%0h exp=0", bus.valid); end
        checks++; if (bus.start_decoder !== 1'b0) begin errors++; $display("FAIL wrst_start got=%0h exp=0", bus.start_decoder); end
        checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL wrst_inst got=%h exp=0", bus.inst); end
        checks++; if (bus.inst_addr !== 32'h0) begin errors++; $display("FAIL wrst_iaddr got=%h exp=0", bus.inst_addr); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL wrst_req got=%0h exp=0", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL wrst_addr got=%h exp=0", bus.mem_addr); end
        // A stale response arriving in IDLE right after reset is ignored.
        rst           = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_data  = 32'hDEADBEEF;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_data  = '0;
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL stale_valid got=%0h exp=0", bus.valid); end
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL stale_req got=%0h exp=1", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL stale_addr got=%h exp=0", bus.mem_addr); end
        serve(2, W000);
        checks++; if (bus.inst !== W000) begin errors++; $display("FAIL refill_inst got=%h exp=%h", bus.inst, W000); end
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL refill_valid got=%0h exp=1", bus.valid); end
    endtask

    initial begin
        bus.issue_signal    = 1'b0;
        bus.next_pc         = '0;
        bus.wrong_predicted = 1'b0;
        bus.correct_pc      = '0;
        bus.mem_ready       = 1'b0;
        bus.mem_data        = '0;
        test_reset();
        test_cold_start();
        test_hit_path();
        test_hold();
        test_flush_miss();
        test_conflict();
        test_back_to_back();
        test_freeze_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
